mips_mult_seq: RTL

Parametrised multicycle integer multiplier for the MIPS execute stage. It is the sequential successor to the single-stage partial-product multiplier. It iterates over CHUNK-bit slices of operand A and handles signed/unsigned operands internally. It adds an optional accumulate/subtract of a 2*WIDTH value (MADD/MSUB style) and a start/busy/done handshake with cancel. The HI/LO register file loads the result on `done`.

---
 rtl/mips_mult_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/mips_mult_seq.sv
// mips_mult_seq: multicycle signed/unsigned multiplier with optional accumulate/subtract and start/done handshake
module mips_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cancel,
    input  logic               signed_op,
    input  logic               acc_en,
    input  logic               acc_sub,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] acc_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              sign_q, sign_d, acc_en_q, acc_en_d, acc_sub_q, acc_sub_d, done_q, done_d;
    logic [PW-1:0]     acc_q, acc_d, sum_q, sum_d, product_q, product_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CHUNK-1:0]  slice;
    logic [PW-1:0]     pp, p;

    // Next-state: latch magnitudes on start, add one shifted partial product per CALC cycle, resolve sign and accumulate in FIN
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        acc_en_d  = acc_en_q;
        acc_sub_d = acc_sub_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        slice     = CHUNK'(a_q >> (int'(cnt_q) * CHUNK));
        pp        = (PW'(slice) * PW'(b_q)) << (int'(cnt_q) * CHUNK);
        p         = sign_q ? ~sum_q + PW'(1) : sum_q;
        unique case (state_q)
            IDLE: if (start) begin
                a_d       = (signed_op && a[WIDTH-1]) ? -a : a;
                b_d       = (signed_op && b[WIDTH-1]) ? -b : b;
                sign_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                acc_en_d  = acc_en;
                acc_sub_d = acc_sub;
                acc_d     = acc_in;
                sum_d     = '0;
                cnt_d     = '0;
                state_d   = CALC;
            end
            CALC: if (cancel) begin
                state_d = IDLE;
            end else begin
                sum_d   = sum_q + pp;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(N - 1)) ? FIN : CALC;
            end
            FIN: begin
                state_d = IDLE;
                if (!cancel) begin
                    product_d = acc_en_q ? (acc_sub_q ? acc_q - p : acc_q + p) : p;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            acc_en_q  <= 1'b0;
            acc_sub_q <= 1'b0;
            acc_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            acc_en_q  <= acc_en_d;
            acc_sub_q <= acc_sub_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = product_q;
endmodule
